// File: rtl/gpio_tx_ab_if.sv
`default_nettype none
// ============================================================================
// Module   : gpio_tx_ab_if
// Brief    : Word hand-off bus into the GPIO serializer (valid/ready + data).
// Revision : 1.0  initial release
// ============================================================================
interface gpio_tx_ab_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  // Producer of words
  modport master (output tx_data, output tx_valid, input tx_ready);
  // Serializer side
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface
`default_nettype wire

// File: rtl/gpio_tx_ab.sv
`default_nettype none
// ============================================================================
// Module   : gpio_tx_ab
// Brief    : Front-panel GPIO bank with a framed, MSB-first serial transmitter
//            on three pins (SCLK/SDAT/FRM). Other pins pass host levels
//            through OUT_MASK. Optional macro GPIO_TX_PARITY_EN appends an
//            even-parity bit after the LSB.
// Revision : 1.0  initial release
// ============================================================================
module gpio_tx_ab #(
  parameter int                        GPIO_REG_WIDTH = 12,
  parameter int                        CLK_DIV_FAC    = 10,
  parameter int                        DATA_WIDTH     = 16,
  parameter int                        SCLK_BIT       = 0,
  parameter int                        SDAT_BIT       = 2,
  parameter int                        FRM_BIT        = 4,
  parameter logic [GPIO_REG_WIDTH-1:0] OUT_MASK       = 12'hD55,
  parameter logic [GPIO_REG_WIDTH-1:0] IO_DDR         = 12'hD55
) (
  input  wire logic                      clk,
  input  wire logic                      reset,
  gpio_tx_ab_if.slave                    tx_if,
  output logic                           busy,
  input  wire logic [GPIO_REG_WIDTH-1:0] gpio_out,
  output logic [GPIO_REG_WIDTH-1:0]      fp_gpio_out,
  output logic [GPIO_REG_WIDTH-1:0]      fp_gpio_ddr
);

`ifdef GPIO_TX_PARITY_EN
  // Parity rides as one extra bit at the bottom of the shift register
  localparam int NBITS = DATA_WIDTH + 1;
`else
  localparam int NBITS = DATA_WIDTH;
`endif
  localparam int DIV_W = (CLK_DIV_FAC > 1) ? $clog2(CLK_DIV_FAC) : 1;
  localparam int BIT_W = $clog2(NBITS + 1);

  localparam logic [DIV_W-1:0] c_div_last = DIV_W'(CLK_DIV_FAC - 1);
  localparam logic [BIT_W-1:0] c_bit_last = BIT_W'(NBITS - 1);

  localparam logic [2:0] c_idle     = 3'd0;
  localparam logic [2:0] c_setup    = 3'd1;
  localparam logic [2:0] c_shift_hi = 3'd2;
  localparam logic [2:0] c_shift_lo = 3'd3;
  localparam logic [2:0] c_hold     = 3'd4;

  logic [2:0]       state_q,   state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [NBITS-1:0] shreg_q,   shreg_d;
  logic             sclk_q,    sclk_d;
  logic             sdat_q,    sdat_d;
  logic             frm_q,     frm_d;
  logic             ready_q,   ready_d;
  logic             w_div_done;
  logic [NBITS-1:0] w_load;

`ifdef GPIO_TX_PARITY_EN
  assign w_load = {tx_if.tx_data, ^tx_if.tx_data};
`else
  assign w_load = tx_if.tx_data;
`endif

  assign w_div_done = (div_cnt_q == c_div_last);

  // State, counters and pin registers; reset clears everything at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= c_idle;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      sclk_q    <= 1'b0;
      sdat_q    <= 1'b0;
      frm_q     <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      sclk_q    <= sclk_d;
      sdat_q    <= sdat_d;
      frm_q     <= frm_d;
      ready_q   <= ready_d;
    end
  end

  // Next-state: every non-idle state lasts one full divider period
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    if (state_q != c_idle) begin
      div_cnt_d = w_div_done ? '0 : div_cnt_q + DIV_W'(1);
    end
    case (state_q)
      c_idle: begin
        // ready_q gates acceptance so nothing is taken on the release edge
        if (tx_if.tx_valid && ready_q) begin
          state_d   = c_setup;
          shreg_d   = w_load;
          bit_cnt_d = '0;
        end
      end
      c_setup: begin
        if (w_div_done) state_d = c_shift_hi;
      end
      c_shift_hi: begin
        if (w_div_done) begin
          if (bit_cnt_q == c_bit_last) begin
            state_d = c_hold;
          end else begin
            state_d   = c_shift_lo;
            shreg_d   = shreg_q << 1;
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      c_shift_lo: begin
        if (w_div_done) state_d = c_shift_hi;
      end
      c_hold: begin
        if (w_div_done) begin
          state_d   = c_idle;
          shreg_d   = '0;
          bit_cnt_d = '0;
        end
      end
      default: state_d = c_idle;
    endcase
  end

  // Pin values for the coming state; SDAT only moves on SETUP/SHIFT_LO entry
  always_comb begin
    frm_d   = (state_d != c_idle);
    sclk_d  = (state_d == c_shift_hi);
    ready_d = (state_d == c_idle);
    sdat_d  = sdat_q;
    if (state_d == c_idle) begin
      sdat_d = 1'b0;
    end else if ((state_d != state_q) &&
                 ((state_d == c_setup) || (state_d == c_shift_lo))) begin
      sdat_d = shreg_d[NBITS-1];
    end
  end

  // Front-panel pins: host levels through the mask, serializer pins from flops
  always_comb begin
    fp_gpio_out           = gpio_out & OUT_MASK;
    fp_gpio_out[SCLK_BIT] = sclk_q;
    fp_gpio_out[SDAT_BIT] = sdat_q;
    fp_gpio_out[FRM_BIT]  = frm_q;
  end

  assign fp_gpio_ddr     = IO_DDR;
  assign busy            = frm_q;
  assign tx_if.tx_ready  = ready_q;

endmodule
`default_nettype wire

// File: doc/gpio_tx_ab.md
GPIO_TX_AB -- requirements
Module: gpio_tx_ab

Interface
REQ-001 SHALL have parameter GPIO_REG_WIDTH, default 12, front-panel GPIO bank width.
REQ-002 SHALL have parameter CLK_DIV_FAC, default 10, clk cycles per serial-clock half-period (legal ≥2).
REQ-003 SHALL have parameter DATA_WIDTH, default 16, serialized word width.
REQ-004 SHALL have parameters SCLK_BIT=0, SDAT_BIT=2, FRM_BIT=4, which are distinct pin indices and must be set in OUT_MASK.
REQ-005 SHALL have parameters OUT_MASK=12'hD55 and IO_DDR=12'hD55 [GPIO_REG_WIDTH-1:0].
REQ-006 SHALL have port clk, input, 1, sole clock; all logic rising-edge.
REQ-007 SHALL have port reset, input, 1, asynchronous active-low reset (low = in reset).
REQ-008 SHALL have port tx_data, input, DATA_WIDTH, word to transmit.
REQ-009 SHALL have port tx_valid, input, 1, tx_data valid.
REQ-010 SHALL have port tx_ready, output, 1, word accepted when tx_valid&tx_ready at a clk edge.
REQ-011 SHALL have port busy, output, 1, frame in progress.
REQ-012 SHALL have port gpio_out, input, GPIO_REG_WIDTH, host-driven levels for non-serializer pins.
REQ-013 SHALL have port fp_gpio_out, output, GPIO_REG_WIDTH, front-panel output levels.
REQ-014 SHALL have port fp_gpio_ddr, output, GPIO_REG_WIDTH, front-panel direction (1 = output).

Function
REQ-015 SHALL drive fp_gpio_ddr = IO_DDR constantly.
REQ-016 SHALL drive fp_gpio_out bits other than SCLK/SDAT/FRM as gpio_out & OUT_MASK, combinationally.
REQ-017 SHALL drive SCLK/SDAT/FRM pins directly from registers (no combinational path from inputs).
REQ-018 SHALL implement FSM IDLE -> SETUP -> SHIFT_HI <-> SHIFT_LO -> HOLD -> IDLE, each state lasting exactly CLK_DIV_FAC cycles except IDLE.
REQ-019 SHALL assert tx_ready only in IDLE; acceptance latches tx_data into a shift register and enters SETUP on the next cycle.
REQ-020 IDLE SHALL drive FRM=0, SCLK=0, SDAT=0, busy=0.
REQ-021 SETUP SHALL drive FRM=1, SCLK=0, SDAT=MSB of the latched word.
REQ-022 SHIFT_HI SHALL drive SCLK=1 with SDAT stable; SHIFT_LO SHALL drive SCLK=0 and present the next bit, MSB first.
REQ-023 After the SHIFT_HI of the last bit, SHALL enter HOLD (FRM=1, SCLK=0, SDAT unchanged) instead of SHIFT_LO.
REQ-024 FRM high time SHALL be exactly (2*DATA_WIDTH+1)*CLK_DIV_FAC cycles; busy SHALL equal FRM.
REQ-025 HOLD SHALL return to IDLE; at least one IDLE cycle (FRM=0) SHALL separate back-to-back frames.
REQ-026 tx_data/tx_valid changes outside acceptance SHALL not affect an in-progress frame.

Reset
REQ-027 While reset=0: state IDLE, SCLK=SDAT=FRM=0, busy=0, tx_ready=0, shift register and counters cleared, asynchronously.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately; no resumption after release.
REQ-029 tx_ready SHALL rise on the first clk edge after reset deasserts.

Configuration
REQ-030 With macro GPIO_TX_PARITY_EN defined, SHALL append one even-parity bit (XOR of word) after LSB as an extra SHIFT_LO/SHIFT_HI period; FRM high time becomes (2*DATA_WIDTH+3)*CLK_DIV_FAC.
REQ-031 Without GPIO_TX_PARITY_EN, SHALL transmit exactly DATA_WIDTH bits and contain no parity logic.

Verification
REQ-032 Defaults, tx_data=16'hA5C3 pulsed valid -> FRM high 330 cycles, 16 SCLK rising edges, SDAT sampled at rising edges = 1010010111000011.
REQ-033 tx_valid held high with 16'hFFFF then 16'h0001 -> two frames, FRM low ≥1 cycle between, tx_ready high only in IDLE.
REQ-034 Reset low at cycle 100 of a frame -> SCLK/SDAT/FRM/busy 0 same cycle; after release tx_ready=1 next edge, no residual bits.
REQ-035 gpio_out=12'hFFF idle and mid-frame -> fp_gpio_out non-serializer bits = 12'hD55 & ~12'h015; fp_gpio_ddr=12'hD55 throughout.
REQ-036 GPIO_TX_PARITY_EN, tx_data=16'h0007 -> 17 SCLK edges, 17th bit=1, FRM high 350 cycles.
